uart_tx_arbiter: RTL and testbench

Shares the single ICE host UART transmitter between several frame sources: the command-response generator, the MBus snoop reporter, GPIO/event reporters. Each requester presents a byte stream terminated by a last flag. The arbiter grants whole frames round-robin, so bytes of different frames never interleave. It drives the UART's tx_latch/tx_data pair and paces bytes off tx_empty.

---
 rtl/uart_tx_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and
// UART handshake widths.
package uart_tx_arbiter_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int BYTE_CNT_W   = 11;
    localparam int BUSY_TIMEOUT = 4;
    localparam int BUSY_CNT_W   = $clog2(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LATCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_t;

    // A zero-length gap still needs a 1-bit counter to keep the port legal.
    function automatic int gap_cnt_w(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid requester after
// last_owner, returned both one-hot and as an index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    logic [IDX_W-1:0] lane;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        lane  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            lane = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (!any && valid[lane]) begin
                any         = 1'b1;
                grant[lane] = 1'b1;
                index       = lane;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one host UART transmitter
// between several byte-stream requesters.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_FRAME  = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_latch,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_empty,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           frame_abort
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = gap_cnt_w(GAP_CYCLES);

    arb_state_t state, state_nxt;

    logic [NUM_REQ-1:0][UART_DATA_W-1:0] lanes;
    logic [IW-1:0]         owner, last_owner, pick_idx;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic                  pick_any;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic                  last_flag;
    logic [BUSY_CNT_W-1:0] busy_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  do_load, do_release, do_abort;

    assign lanes = req_data;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IW)) u_pick (
        .valid      (req_valid),
        .last_owner (last_owner),
        .grant      (pick_gnt),
        .index      (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        state_nxt  = state;
        do_load    = 1'b0;
        do_release = 1'b0;
        do_abort   = 1'b0;
        case (state)
            ST_IDLE:      if (pick_any) state_nxt = ST_LOAD;
            ST_LOAD: begin
                // Owner keeps the UART while its frame is open, even if it stalls.
                if (req_valid[owner]) begin
                    do_load   = 1'b1;
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH:     state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                // A fast UART may finish before we ever see tx_empty drop.
                if (!tx_empty || busy_cnt == BUSY_CNT_W'(BUSY_TIMEOUT - 1))
                    state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_empty) begin
                    if (last_flag) begin
                        do_release = 1'b1;
                    end else if (byte_cnt == BYTE_CNT_W'(MAX_FRAME)) begin
                        do_release = 1'b1;
                        do_abort   = 1'b1;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                    if (do_release)
                        state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP:       if (gap_cnt == '0) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Consumption is acknowledged in the capture cycle; reset cancels the capture.
    assign req_ready = (do_load && !reset) ? grant : '0;
    assign tx_latch  = (state == ST_LATCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            owner       <= '0;
            last_owner  <= IW'(NUM_REQ - 1);
            byte_cnt    <= '0;
            last_flag   <= 1'b0;
            busy_cnt    <= '0;
            gap_cnt     <= '0;
            tx_data     <= '0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_abort <= do_abort;

            if (state == ST_IDLE && pick_any) begin
                grant    <= pick_gnt;
                owner    <= pick_idx;
                byte_cnt <= '0;
            end

            if (do_load) begin
                tx_data   <= lanes[owner];
                last_flag <= req_last[owner];
                if (byte_cnt != '1)
                    byte_cnt <= byte_cnt + 1'b1;
            end

            if (state == ST_LATCH)
                busy_cnt <= '0;
            else if (state == ST_WAIT_BUSY)
                busy_cnt <= busy_cnt + 1'b1;

            if (do_release) begin
                last_owner <= owner;
                grant      <= '0;
                gap_cnt    <= GW'(GAP_CYCLES - 1);
            end else if (state == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: lane drivers, UART model, and a frame-level
// round-robin reference model over per-lane byte queues.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int GAP  = 16;
    localparam int MAXF = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           tx_latch, tx_empty, frame_abort;
    logic [7:0]     tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .MAX_FRAME(MAXF)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_latch    (tx_latch),
        .tx_data     (tx_data),
        .tx_empty    (tx_empty),
        .grant       (grant),
        .frame_abort (frame_abort)
    );

    logic [8:0]   lq [N][$];
    logic [8:0]   mq [N][$];
    logic [N-1:0] hold = '0;
    logic [N-1:0] hs = '0;
    logic         fast_uart = 1'b0;

    logic [N+7:0] logq[$];
    logic [N+7:0] expq[$];
    int latch_cnt = 0, abort_cnt = 0, rel_cnt = 0, bad_grant = 0;
    int min_gap = 1000, idle_run = 0;
    bit seen_grant = 0;
    logic [N-1:0] prev_g = '0;

    int mlast = N - 1, mown = -1, mcnt = 0, exp_aborts = 0;
    int nchk = 0, nfail = 0;

    // Lane drivers: present queue head, retire it once a handshake was seen.
    initial begin
        req_valid = '0; req_last = '0; req_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (hs[i] && lq[i].size() > 0) void'(lq[i].pop_front());
                if (lq[i].size() > 0 && !hold[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = lq[i][0][7:0];
                    req_last[i]        = lq[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = '0;
                    req_last[i]        = 1'b0;
                end
            end
            #1;
            hs = req_valid & req_ready;
        end
    end

    // UART: tx_empty drops after a latch and rises after a random byte time.
    initial begin
        int bt;
        tx_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_latch && !fast_uart) begin
                bt = $urandom_range(3, 10);
                @(posedge clk); #1 tx_empty = 1'b0;
                repeat (bt) @(posedge clk);
                #1 tx_empty = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #1;
            if (tx_latch) begin
                logq.push_back({grant, tx_data});
                latch_cnt++;
            end
            if (frame_abort) abort_cnt++;
            if (prev_g != '0 && grant == '0) rel_cnt++;
            if (reset) begin
                seen_grant = 0;
                idle_run   = 0;
            end else begin
                if ($countones(grant) > 1) bad_grant++;
                if (grant != '0 && prev_g != '0 && grant != prev_g) bad_grant++;
                if (grant == '0) begin
                    idle_run++;
                end else if (prev_g == '0) begin
                    if (seen_grant && idle_run < min_gap) min_gap = idle_run;
                    seen_grant = 1;
                    idle_run   = 0;
                end
            end
            prev_g = grant;
        end
    end

    task automatic cyc();
        @(negedge clk); #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nchk++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic push_byte(input int lane, input logic [7:0] d, input logic last);
        lq[lane].push_back({last, d});
        mq[lane].push_back({last, d});
    endtask

    task automatic push_frame(input int lane, input int len, input logic with_last);
        logic [7:0] d;
        for (int j = 0; j < len; j++) begin
            d = 8'($urandom);
            push_byte(lane, d, with_last && (j == len - 1));
        end
    endtask

    // Whole frames go round-robin among lanes holding bytes; a grant ends at
    // a last flag or after MAXF bytes (abort), an open frame keeps its owner.
    task automatic model_run();
        int pick;
        logic [8:0]   b;
        logic [N-1:0] oh;
        forever begin
            if (mown < 0) begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && mq[(mlast + k) % N].size() > 0) pick = (mlast + k) % N;
                if (pick < 0) return;
                mown = pick;
                mcnt = 0;
            end
            if (mq[mown].size() == 0) return;
            b = mq[mown].pop_front();
            oh = '0;
            oh[mown] = 1'b1;
            expq.push_back({oh, b[7:0]});
            mcnt++;
            if (b[8] || mcnt == MAXF) begin
                if (!b[8]) exp_aborts++;
                mlast = mown;
                mown  = -1;
            end
        end
    endtask

    task automatic clear_logs();
        logq.delete();
        expq.delete();
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_count"}, logq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < logq.size(); i++)
            chk({tag, "_byte"}, 32'(logq[i]), 32'(expq[i]));
        chk({tag, "_aborts"}, abort_cnt, exp_aborts);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((logq.size() < expq.size() || (mown < 0 && grant != '0) || !tx_empty) && t < 5000) begin
            cyc();
            t++;
        end
        repeat (3) cyc();
        cmp_log(tag);
    endtask

    initial begin
        int t, l0, r0, bad;
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst_grant",     grant,       0);
        chk("rst_tx_latch",  tx_latch,    0);
        chk("rst_tx_data",   tx_data,     0);
        chk("rst_req_ready", req_ready,   0);
        chk("rst_abort",     frame_abort, 0);
        reset = 1'b0;
        cyc();

        // Single two-byte frame on lane 0.
        clear_logs();
        l0 = latch_cnt;
        push_byte(0, 8'h5A, 1'b0);
        push_byte(0, 8'hA5, 1'b1);
        model_run();
        drain("single");
        chk("single_latches", latch_cnt - l0, 2);
        chk("single_b0", 32'(logq[0]), {4'b0001, 8'h5A});
        chk("single_b1", 32'(logq[1]), {4'b0001, 8'hA5});

        // Lanes 1 and 3 request together.
        clear_logs();
        push_frame(1, 3, 1'b1);
        push_frame(3, 3, 1'b1);
        model_run();
        drain("simul");
        chk("simul_first", logq[0][11:8], 4'b0010);
        chk("simul_second", logq[3][11:8], 4'b1000);

        // Lanes 0 and 2 keep re-requesting one-byte frames.
        clear_logs();
        for (int f = 0; f < 4; f++) begin
            push_frame(0, 1, 1'b1);
            push_frame(2, 1, 1'b1);
        end
        model_run();
        drain("fair");
        for (int i = 0; i < 8; i++)
            chk("fair_order", logq[i][11:8], (i % 2) ? 4'b0100 : 4'b0001);

        // Lane 2 stalls mid-frame while lane 0 waits.
        clear_logs();
        push_frame(2, 3, 1'b1);
        model_run();
        t = 0;
        while (!hs[2] && t < 500) begin cyc(); t++; end
        chk("stall_first_ack", hs[2], 1);
        hold[2] = 1'b1;
        push_frame(0, 2, 1'b1);
        model_run();
        repeat (15) cyc();
        l0  = latch_cnt;
        bad = 0;
        repeat (100) begin
            cyc();
            if (grant !== 4'b0100) bad++;
        end
        chk("stall_grant_held", bad, 0);
        chk("stall_no_latch", latch_cnt - l0, 0);
        hold[2] = 1'b0;
        drain("stall");
        chk("stall_lane2_last", logq[2][11:8], 4'b0100);
        chk("stall_lane0_after", logq[3][11:8], 4'b0001);

        // Random traffic; round 1 uses a UART that never shows busy.
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            fast_uart = (r == 1);
            for (int l = 0; l < N; l++)
                if ($urandom_range(0, 2) != 0 || l == r)
                    repeat ($urandom_range(1, 2)) push_frame(l, $urandom_range(1, 6), 1'b1);
            model_run();
            drain($sformatf("rnd%0d", r));
        end
        fast_uart = 1'b0;

        // Six bytes without a last flag: cut at MAXF, rest as a new grant.
        clear_logs();
        r0 = rel_cnt;
        push_frame(1, 6, 1'b0);
        model_run();
        t = 0;
        while (logq.size() < 6 && t < 3000) begin cyc(); t++; end
        while (tx_empty && t < 3000) begin cyc(); t++; end
        cyc();
        cmp_log("abort");
        chk("abort_releases", rel_cnt - r0, 1);
        chk("abort_open_grant", grant, 4'b0010);

        // Reset while the sixth byte is still shifting out.
        reset = 1'b1;
        cyc();
        chk("midrst_grant", grant, 0);
        chk("midrst_latch", tx_latch, 0);
        chk("midrst_ready", req_ready, 0);
        for (int i = 0; i < N; i++) begin
            lq[i].delete();
            mq[i].delete();
        end
        mlast = N - 1;
        mown  = -1;
        cyc();
        reset = 1'b0;
        t = 0;
        while (!tx_empty && t < 100) begin cyc(); t++; end
        clear_logs();
        push_frame(2, 2, 1'b1);
        push_frame(0, 2, 1'b1);
        model_run();
        drain("postrst");
        chk("postrst_first", logq[0][11:8], 4'b0001);

        chk("grant_onehot_no_interleave", bad_grant, 0);
        chk("min_gap_ok", 32'(min_gap >= GAP), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
